tft_layer_mixer: RTL

Parametrised TFT pixel compositor: merges up to `NUM_LAYERS` pixel sources into one RGB565 stream, resolving overlapping layers by priority with per-layer transparency. Sources include character/digit ROMs, solid fills and an SDRAM image. It also contains the digit-cycling ticker that selects which digit glyph ROM is shown. The block sits between the TFT timing/coordinate generators plus glyph ROMs and the TFT output driver, and compensates ROM read latency internally.

---
 rtl/tft_pkg.sv | 24 ++
 rtl/tft_digit_ticker.sv | 64 ++++++
 rtl/tft_layer_mixer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tft_pkg.sv
// Shared TFT definitions: RGB565 colour constants, field widths and layer modes.
package tft_pkg;

  localparam int unsigned PIX_W   = 16;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [PIX_W-1:0] RGB_BLACK  = 16'h0000;
  localparam logic [PIX_W-1:0] RGB_BLUE   = 16'h001F;
  localparam logic [PIX_W-1:0] RGB_RED    = 16'hF800;
  localparam logic [PIX_W-1:0] RGB_PURPLE = 16'hF81F;
  localparam logic [PIX_W-1:0] RGB_GREEN  = 16'h07E0;
  localparam logic [PIX_W-1:0] RGB_CYAN   = 16'h07FF;
  localparam logic [PIX_W-1:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [PIX_W-1:0] RGB_WHITE  = 16'hFFFF;

  typedef enum logic [MODE_W-1:0] {
    LM_OFF       = 2'b00,
    LM_DIRECT    = 2'b01,
    LM_MONO_FILL = 2'b10,
    LM_MONO_KEY  = 2'b11
  } layer_mode_t;

endpackage

// File: rtl/tft_digit_ticker.sv
// Digit ticker: free-running period counter that advances the shown digit,
// with pause and single-step control.
// Ports: clk, rst_n, digit_pause (freeze), digit_step (advance now),
//        digit_sel (current digit), digit_wrap (pulse on DIGIT_MAX -> 0).
module tft_digit_ticker
  import tft_pkg::*;
#(
  parameter int unsigned DIGIT_PERIOD = 16650000,
  parameter int unsigned DIGIT_MAX    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               digit_pause,
  input  logic               digit_step,
  output logic [DIGIT_W-1:0] digit_sel,
  output logic               digit_wrap
);

  localparam int unsigned CNT_W = $clog2(DIGIT_PERIOD);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] sel_q, sel_d;
  logic               wrap_q, wrap_d;
  logic               tc_c, adv_c;

  // Terminal count only fires while counting; a step coinciding with it
  // still yields a single advance.
  always_comb begin
    tc_c   = !digit_pause && (cnt_q == CNT_W'(DIGIT_PERIOD - 1));
    adv_c  = tc_c || digit_step;
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (adv_c) begin
      cnt_d = '0;
    end else if (!digit_pause) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (adv_c) begin
      if (sel_q == DIGIT_W'(DIGIT_MAX)) begin
        sel_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sel_d = sel_q + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      wrap_q <= wrap_d;
    end
  end

  assign digit_sel  = sel_q;
  assign digit_wrap = wrap_q;

endmodule

// File: rtl/tft_layer_mixer.sv
// TFT layer compositor: delays requests to meet ROM data, resolves the
// highest-priority opaque layer per pixel and registers the RGB565 result.
// Also hosts the digit ticker that drives the digit glyph ROM mux.
// Ports: clk_vga, rst_n, pix_en, layer_req/mode/color/pix (per layer),
//        bg_color, digit_pause, digit_step, digit_sel, digit_wrap,
//        display_data, display_de.
module tft_layer_mixer
  import tft_pkg::*;
#(
  parameter int unsigned NUM_LAYERS   = 4,
  parameter int unsigned ROM_LATENCY  = 1,
  parameter int unsigned DIGIT_PERIOD = 16650000,
  parameter int unsigned DIGIT_MAX    = 9
) (
  input  logic                          clk_vga,
  input  logic                          rst_n,
  input  logic                          pix_en,
  input  logic [NUM_LAYERS-1:0]         layer_req,
  input  logic [MODE_W*NUM_LAYERS-1:0]  layer_mode,
  input  logic [PIX_W*NUM_LAYERS-1:0]   layer_color,
  input  logic [PIX_W*NUM_LAYERS-1:0]   layer_pix,
  input  logic [PIX_W-1:0]              bg_color,
  input  logic                          digit_pause,
  input  logic                          digit_step,
  output logic [DIGIT_W-1:0]            digit_sel,
  output logic                          digit_wrap,
  output logic [PIX_W-1:0]              display_data,
  output logic                          display_de
);

  logic [NUM_LAYERS-1:0] req_dly_c;
  logic                  en_dly_c;

  // Request/enable delay line so requests line up with ROM data.
  if (ROM_LATENCY == 0) begin : g_no_dly
    assign req_dly_c = layer_req;
    assign en_dly_c  = pix_en;
  end else begin : g_dly
    localparam int unsigned DW = ROM_LATENCY * NUM_LAYERS;
    logic [DW-1:0]          req_sh_q, req_sh_d;
    logic [ROM_LATENCY-1:0] en_sh_q, en_sh_d;

    always_comb begin
      req_sh_d = DW'({req_sh_q, layer_req});
      en_sh_d  = ROM_LATENCY'({en_sh_q, pix_en});
    end

    always_ff @(posedge clk_vga or negedge rst_n) begin
      if (!rst_n) begin
        req_sh_q <= '0;
        en_sh_q  <= '0;
      end else begin
        req_sh_q <= req_sh_d;
        en_sh_q  <= en_sh_d;
      end
    end

    assign req_dly_c = req_sh_q[DW-1 -: NUM_LAYERS];
    assign en_dly_c  = en_sh_q[ROM_LATENCY-1];
  end

  // Priority chain: entry g holds the winner among layers >= g; the top
  // entry is the "nothing covers this pixel" background.
  logic [NUM_LAYERS:0] hit_c;
  logic [PIX_W-1:0]    pix_ch_c [NUM_LAYERS+1];

  assign hit_c[NUM_LAYERS]    = 1'b0;
  assign pix_ch_c[NUM_LAYERS] = bg_color;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    layer_mode_t      mode_c;
    logic [PIX_W-1:0] pix_c, col_c, out_c;
    logic             opq_c;

    assign mode_c = layer_mode_t'(layer_mode[MODE_W*g +: MODE_W]);
    assign pix_c  = layer_pix[PIX_W*g +: PIX_W];
    assign col_c  = layer_color[PIX_W*g +: PIX_W];

    // MONO_KEY with a clear bit is transparent and lets lower layers through.
    assign opq_c = req_dly_c[g] &&
                   ((mode_c == LM_DIRECT) || (mode_c == LM_MONO_FILL) ||
                    ((mode_c == LM_MONO_KEY) && pix_c[0]));
    assign out_c = (mode_c == LM_DIRECT) ? pix_c : (pix_c[0] ? col_c : bg_color);

    assign hit_c[g]    = hit_c[g+1] || opq_c;
    assign pix_ch_c[g] = (!hit_c[g+1] && opq_c) ? out_c : pix_ch_c[g+1];
  end

  logic [PIX_W-1:0] data_q, data_d;
  logic             de_q, de_d;

  // Blank outside the active area.
  always_comb begin
    data_d = RGB_BLACK;
    de_d   = en_dly_c;
    if (en_dly_c) begin
      data_d = pix_ch_c[0];
    end
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      de_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      de_q   <= de_d;
    end
  end

  assign display_data = data_q;
  assign display_de   = de_q;

  tft_digit_ticker #(
    .DIGIT_PERIOD (DIGIT_PERIOD),
    .DIGIT_MAX    (DIGIT_MAX)
  ) u_ticker (
    .clk         (clk_vga),
    .rst_n       (rst_n),
    .digit_pause (digit_pause),
    .digit_step  (digit_step),
    .digit_sel   (digit_sel),
    .digit_wrap  (digit_wrap)
  );

endmodule
